pconv_feeder: RTL

- Stream sequencer that drives one pconv_unit.
- For each output channel it fetches that channel's packed weight vector, bias and shift from a parameter memory, then streams every pixel's packed INPUT_CHANNEL vector from a feature-map buffer.
- Produces the pconv_unit input_vld/input_din/weight_din/bias_din/shift_din signals, plus pixel and channel tags so the downstream writer can place each result.

---
 rtl/pconv_feeder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pconv_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pconv_feeder
// Purpose  : Sequences one full layer pass for a pconv_unit. For each output
//            channel it loads weight/bias/shift from parameter memory, then
//            streams every pixel's packed input vector from the feature-map
//            buffer, tagging each beat with its pixel and channel index.
// Revision : 1.0 - initial release
// ============================================================================
module pconv_feeder #(
  parameter int N              = 16,
  parameter int INPUT_CHANNEL  = 3,
  parameter int OUTPUT_CHANNEL = 8,
  parameter int FMAP_SIZE      = 28,
  parameter int ADDR_W         = 10,
  parameter int OC_W           = 3,
  parameter int PE_LATENCY     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       en,
  output logic                       busy,
  output logic                       done,
  output logic                       fmap_rd_en,
  output logic [ADDR_W-1:0]          fmap_rd_addr,
  input  logic [INPUT_CHANNEL*N-1:0] fmap_rd_data,
  output logic                       param_rd_en,
  output logic [OC_W-1:0]            param_rd_addr,
  input  logic [INPUT_CHANNEL*N-1:0] wt_rd_data,
  input  logic [31:0]                bias_rd_data,
  input  logic [4:0]                 shift_rd_data,
  output logic                       pe_input_vld,
  output logic [INPUT_CHANNEL*N-1:0] pe_input_din,
  output logic [INPUT_CHANNEL*N-1:0] pe_weight_din,
  output logic [31:0]                pe_bias_dout,
  output logic [4:0]                 pe_shift_dout,
  output logic [ADDR_W-1:0]          pe_pix,
  output logic [OC_W-1:0]            pe_oc
);

  localparam int P         = FMAP_SIZE * FMAP_SIZE;
  // Two read-pipeline stages plus the pconv_unit latency must elapse before
  // the parameters may change for the next channel.
  localparam int DRAIN_LEN = 2 + PE_LATENCY;
  localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  localparam logic [ADDR_W-1:0] c_last_pix   = ADDR_W'(P - 1);
  localparam logic [OC_W-1:0]   c_last_oc    = OC_W'(OUTPUT_CHANNEL - 1);
  localparam logic [DW-1:0]     c_last_drain = DW'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT_P = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pix;
  logic [OC_W-1:0]    r_oc;
  logic [DW-1:0]      r_drain;

  // Stage-1 of the read pipeline: strobe and tags of the read issued last cycle.
  logic               r_v1;
  logic [ADDR_W-1:0]  r_pix1;
  logic [OC_W-1:0]    r_oc1;

  // Reads are issued in the same cycle en is seen so a pause takes effect at once.
  assign fmap_rd_en   = (r_state == S_STREAM) && en;
  assign fmap_rd_addr = r_pix;

  // Layer sequencer: channel loop, parameter fetch, pixel stream and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      param_rd_en   <= 1'b0;
      param_rd_addr <= '0;
      r_oc          <= '0;
      r_pix         <= '0;
      r_drain       <= '0;
      pe_weight_din <= '0;
      pe_bias_dout  <= '0;
      pe_shift_dout <= '0;
    end else begin
      param_rd_en <= 1'b0;
      done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_LOAD;
            busy          <= 1'b1;
            param_rd_en   <= 1'b1;
            param_rd_addr <= r_oc;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT_P;
        end
        S_WAIT_P: begin
          // Parameter data returns now; hold it until the next channel's fetch.
          pe_weight_din <= wt_rd_data;
          pe_bias_dout  <= bias_rd_data;
          pe_shift_dout <= shift_rd_data;
          r_pix         <= '0;
          r_state       <= S_STREAM;
        end
        S_STREAM: begin
          if (en) begin
            r_pix <= r_pix + ADDR_W'(1);
            if (r_pix == c_last_pix) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == c_last_drain) begin
            if (r_oc != c_last_oc) begin
              r_oc          <= r_oc + OC_W'(1);
              param_rd_en   <= 1'b1;
              param_rd_addr <= r_oc + OC_W'(1);
              r_state       <= S_LOAD;
            end else begin
              r_oc    <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_FIN;
            end
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Two-stage read pipeline: tags follow each read until its data is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1         <= 1'b0;
      r_pix1       <= '0;
      r_oc1        <= '0;
      pe_input_vld <= 1'b0;
      pe_input_din <= '0;
      pe_pix       <= '0;
      pe_oc        <= '0;
    end else begin
      r_v1         <= fmap_rd_en;
      r_pix1       <= r_pix;
      r_oc1        <= r_oc;
      pe_input_vld <= r_v1;
      if (r_v1) begin
        pe_input_din <= fmap_rd_data;
        pe_pix       <= r_pix1;
        pe_oc        <= r_oc1;
      end
    end
  end

endmodule
`default_nettype wire
